// File: rtl/clk_ctrl_pkg.sv
//------------------------------------------------------------------------------
// clk_ctrl_pkg : shared types and constants for the clock divider controller
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clk_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   localparam int unsigned C_RESET_DIV = 1;

endpackage

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//------------------------------------------------------------------------------
// clk_div_ctrl : programmable clock-enable divider with glitch-free ratio update
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 8,
   parameter int unsigned RESET_DIV = C_RESET_DIV
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   output logic                 clk_en_o,
   output logic                 clk_div_o,
   output logic [DIV_WIDTH-1:0] div_o
);

   localparam logic [DIV_WIDTH-1:0] c_reset_div = DIV_WIDTH'(RESET_DIV);
   localparam logic [DIV_WIDTH-1:0] c_one       = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH:0]   c_one_w     = (DIV_WIDTH+1)'(1);

   state_e                 r_state, w_state_nxt;
   logic [DIV_WIDTH-1:0]   r_cnt, w_cnt_nxt;
   logic [DIV_WIDTH-1:0]   r_div, w_div_nxt;
   logic [DIV_WIDTH-1:0]   r_pend, w_pend_nxt;
   logic [DIV_WIDTH-1:0]   w_cnt_step;
   logic [DIV_WIDTH:0]     w_half;
   logic                   w_active;
   logic                   w_bypass;
   logic                   w_bnd;
   logic                   w_hs;

   // All output decode uses registered state only; no input reaches an output.
   assign w_active    = (r_state != ST_IDLE);
   assign w_bypass    = (r_div <= c_one);
   assign w_half      = ({1'b0, r_div} + c_one_w) >> 1;
   assign w_bnd       = w_active && (w_bypass || (r_cnt == r_div - c_one));
   assign w_cnt_step  = w_bnd ? '0 : r_cnt + c_one;

   assign cfg_ready_o = (r_state != ST_PEND);
   assign clk_en_o    = w_bnd;
   assign clk_div_o   = w_active && (w_bypass || ({1'b0, r_cnt} < w_half));
   assign div_o       = r_div;
   assign w_hs        = cfg_valid_i && cfg_ready_o;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_div_nxt   = r_div;
      w_pend_nxt  = r_pend;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_hs) begin
               w_div_nxt = cfg_div_i;
            end
            if (en_i) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en_i) begin
               // A ratio offered on the disabling edge takes effect immediately.
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               if (w_hs) begin
                  w_div_nxt = cfg_div_i;
               end
            end else begin
               w_cnt_nxt = w_cnt_step;
               if (w_hs) begin
                  w_pend_nxt  = cfg_div_i;
                  w_state_nxt = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (!en_i) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_div_nxt   = r_pend;
            end else if (w_bnd) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_div_nxt   = r_pend;
            end else begin
               w_cnt_nxt = w_cnt_step;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_div   <= c_reset_div;
         r_pend  <= c_reset_div;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//------------------------------------------------------------------------------
// tb_clk_div_ctrl : scoreboard bench for clk_div_ctrl against a period model
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

   localparam int W  = 8;
   localparam int RD = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_div;
   logic         clk_en;
   logic         clk_div;
   logic [W-1:0] div;

   clk_div_ctrl #(.DIV_WIDTH(W), .RESET_DIV(RD)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_div_i   (cfg_div),
      .clk_en_o    (clk_en),
      .clk_div_o   (clk_div),
      .div_o       (div)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         chk;
      logic         tick;
      logic         lvl;
      logic         rdy;
      logic [W-1:0] div;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference model: running flag, ratio, position within the current period,
   // and an optional waiting ratio.
   bit m_known = 0;
   bit m_run   = 0;
   bit m_pv    = 0;
   int m_div   = RD;
   int m_pend  = RD;
   int m_pos   = 0;

   function automatic exp_t predict();
      exp_t e;
      bit   byp;
      byp    = (m_div <= 1);
      e.chk  = m_known;
      e.tick = m_run && (byp || m_pos == m_div - 1);
      e.lvl  = m_run && (byp || m_pos < (m_div + 1) / 2);
      e.rdy  = !m_pv;
      e.div  = W'(m_div);
      return e;
   endfunction

   task automatic model_edge(input bit rstn, input bit e, input bit v, input int c);
      bit bnd;
      bit hs;
      if (!rstn) begin
         m_known = 1; m_run = 0; m_pv = 0; m_div = RD; m_pend = RD; m_pos = 0;
         return;
      end
      bnd = m_run && (m_div <= 1 || m_pos == m_div - 1);
      hs  = v && !m_pv;
      if (!m_run) begin
         if (v) m_div = c;
         if (e) begin m_run = 1; m_pos = 0; end
      end else if (!e) begin
         if (m_pv) m_div = m_pend;
         if (hs)   m_div = c;
         m_run = 0; m_pv = 0; m_pos = 0;
      end else if (m_pv && bnd) begin
         m_div = m_pend; m_pv = 0; m_pos = 0;
      end else begin
         m_pos = bnd ? 0 : m_pos + 1;
         if (hs) begin m_pend = c; m_pv = 1; end
      end
   endtask

   task automatic step(input bit rstn, input bit e, input bit v, input int c);
      rst_n     = rstn;
      en        = e;
      cfg_valid = v;
      cfg_div   = W'(c);
      q.push_back(predict());
      @(posedge clk);
      model_edge(rstn, e, v, c);
      #1;
   endtask

   task automatic run(input int n, input bit e);
      for (int i = 0; i < n; i++) step(1, e, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         if (x.chk) begin
            n_vec++;
            if (clk_en !== x.tick) begin
               n_miss++;
               $display("FAIL clk_en_o t=%0t got %b want %b", $time, clk_en, x.tick);
            end
            if (clk_div !== x.lvl) begin
               n_miss++;
               $display("FAIL clk_div_o t=%0t got %b want %b", $time, clk_div, x.lvl);
            end
            if (cfg_ready !== x.rdy) begin
               n_miss++;
               $display("FAIL cfg_ready_o t=%0t got %b want %b", $time, cfg_ready, x.rdy);
            end
            if (div !== x.div) begin
               n_miss++;
               $display("FAIL div_o t=%0t got %0d want %0d", $time, div, x.div);
            end
         end
      end
   end

   initial begin
      rst_n = 0; en = 0; cfg_valid = 0; cfg_div = '0;
      @(posedge clk); #1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      run(2, 0);

      // basic divide by 4
      step(1, 0, 1, 4);
      step(1, 1, 0, 0);
      run(13, 1);

      // odd ratio 5
      run(2, 0);
      step(1, 0, 1, 5);
      run(16, 1);

      // mid-period change 6 -> 3, with offers ignored while pending
      run(2, 0);
      step(1, 0, 1, 6);
      step(1, 1, 0, 0);
      run(2, 1);
      step(1, 1, 1, 3);
      for (int i = 0; i < 4; i++) step(1, 1, i[0], 9);
      run(10, 1);

      // bypass with D=0 and D=1, then change to 2
      run(2, 0);
      step(1, 0, 1, 0);
      run(4, 1);
      step(1, 1, 1, 1);
      run(3, 1);
      step(1, 1, 1, 2);
      run(7, 1);

      // disable while a ratio is pending
      run(2, 0);
      step(1, 0, 1, 8);
      step(1, 1, 0, 0);
      run(3, 1);
      step(1, 1, 1, 2);
      run(1, 1);
      run(3, 0);
      run(8, 1);

      // reset at cnt 3 of D=8 with a pending ratio
      run(2, 0);
      step(1, 0, 1, 8);
      step(1, 1, 0, 0);
      step(1, 1, 1, 5);
      run(2, 1);
      step(0, 1, 0, 0);
      run(4, 0);
      run(10, 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int c;
         c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 9));
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 9) < 3),
              c);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8: width of the divide ratio.
REQ-002 SHALL have parameter RESET_DIV, default 1: divide ratio loaded at reset.
REQ-003 SHALL have port clk_i, input, 1: the only clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port en_i, input, 1: divider run enable.
REQ-006 SHALL have port cfg_valid_i, input, 1: new ratio offered.
REQ-007 SHALL have port cfg_ready_o, output, 1: ratio can be accepted.
REQ-008 SHALL have port cfg_div_i, input, DIV_WIDTH: requested ratio D.
REQ-009 SHALL have port clk_en_o, output, 1: one-cycle tick, once per divided period.
REQ-010 SHALL have port clk_div_o, output, 1: divided-clock level.
REQ-011 SHALL have port div_o, output, DIV_WIDTH: ratio currently in effect.

Function
REQ-012 SHALL implement FSM IDLE / RUN / PEND; PEND means RUN with an accepted, not-yet-applied ratio.
REQ-013 SHALL accept a ratio on a cycle with cfg_valid_i && cfg_ready_o.
- The ratio is held in a pending register.
- cfg_ready_o is 1 in IDLE and RUN, 0 in PEND.
REQ-014 SHALL treat D of 0 or 1 as bypass: clk_en_o=1 and clk_div_o=1 on every RUN cycle.
REQ-015 SHALL count cnt from 0 to D-1 in RUN and wrap to 0; for D>=2:
- clk_en_o=1 exactly when cnt==D-1;
- clk_div_o=1 when cnt<ceil(D/2), else 0.
REQ-016 SHALL decode clk_en_o and clk_div_o only from registered state; no combinational path from any input to any output.
REQ-017 SHALL set cnt=0 and enter RUN at the clock edge where IDLE samples en_i=1; first tick occurs D cycles after that edge (cnt==D-1).
REQ-018 SHALL apply a ratio accepted in IDLE at the next edge; div_o updates then.
REQ-019 SHALL apply a pending ratio only at a period boundary (edge where cnt==D-1 and clk_en_o=1):
- div_o takes the new value and cnt restarts at 0;
- state returns to RUN, so no truncated or stretched divided period is emitted.
REQ-020 SHALL, in bypass, treat every cycle as a period boundary, so a pending ratio applies at the next edge.
REQ-021 SHALL, when en_i=0 is sampled in RUN or PEND, go to IDLE at that edge:
- cnt=0; clk_en_o=0 and clk_div_o=0 while in IDLE;
- any pending ratio is applied at that same edge.
REQ-022 SHALL, when a boundary and a handshake occur in the same RUN cycle, apply nothing new that cycle and enter PEND holding the new ratio.
REQ-023 SHALL keep the prior div_o and period unaffected while cfg_valid_i toggles with cfg_ready_o=0.

Reset
REQ-024 SHALL, on a clk_i edge with rst_ni=0:
- state=IDLE, cnt=0, div_o=RESET_DIV, pending register=RESET_DIV;
- cfg_ready_o=1, clk_en_o=0, clk_div_o=0.
REQ-025 SHALL discard any pending ratio on reset mid-operation; no tick or level glitch follows reset release until en_i is sampled high.

Structure
REQ-026 SHALL place the FSM state enum and the RESET_DIV default constant in the shared package clk_ctrl_pkg.
REQ-027 SHALL be a single module with no sub-modules; the ratio counter stays inline.

Verification
REQ-028 SHALL verify basic divide: reset, cfg 4 accepted in IDLE, en_i=1 -> clk_en_o every 4th cycle, first 4 cycles after the enable edge; clk_div_o pattern 1,1,0,0.
REQ-029 SHALL verify an odd ratio: D=5 -> clk_div_o 1,1,1,0,0 repeating; one tick per 5 cycles.
REQ-030 SHALL verify a mid-period change: running D=6 at cnt=2, cfg 3 offered, then:
- accepted, cfg_ready_o=0, remaining period stays 6;
- subsequent period is 3; div_o changes at the boundary edge; cfg_ready_o returns to 1.
REQ-031 SHALL verify bypass: D=0 and D=1 -> clk_en_o and clk_div_o constant 1 in RUN; a cfg 2 applies on the next edge.
REQ-032 SHALL verify disable with pending: D=8 with cfg 2 pending, en_i=0 -> IDLE next edge, outputs 0, div_o=2; re-enable gives a tick every 2 cycles.
REQ-033 SHALL verify reset mid-run: rst_ni=0 at cnt=3 of D=8 with cfg pending -> div_o=RESET_DIV, outputs 0, cfg_ready_o=1, no tick until re-enabled.
